// File: rtl/acc_tx.sv
`default_nettype none
// ============================================================================
// Module   : acc_tx
// Purpose  : Bit-serial transmitter for the accumulator link. A 128-bit
//            operand buffer is written byte-wise. On start it is snapshotted
//            and sent as WORDS 32-bit frames on add/tx, word 0 first, MSB
//            first. Consecutive frames are separated by GAP idle cycles.
// Params   : WORDS (1..4) frames per burst, GAP (>=1) idle cycles between
//            frames.
// Ports    : clk, nRst (async, active-low)
//            wr/waddr/wdata    byte write into the operand buffer
//            start             begin a burst (ignored unless idle)
//            busy, done        burst in flight / one-cycle end pulse
//            add, tx           frame enable / serial data (registered)
//            chk_sel/chk_data  checksum byte readback (combinational)
// Options  : `define ACC_TX_CHECKSUM_EN to build a 128-bit running sum of
//            transmitted words mirroring the receiver; otherwise chk_data
//            reads 8'h00.
// Revision : 1.0 - initial release
// ============================================================================
module acc_tx #(
    parameter int WORDS = 4,
    parameter int GAP   = 1
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       wr,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       add,
    output logic       tx,
    input  logic [3:0] chk_sel,
    output logic [7:0] chk_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam int              c_GW        = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'(GAP - 1);
    localparam logic [1:0]      c_WORD_LAST = 2'(WORDS - 1);

    state_t          r_state;
    logic [1:0]      r_word;
    logic [4:0]      r_bit;
    logic [c_GW-1:0] r_gap;
    logic [127:0]    r_buf;
    logic [127:0]    r_snap;

    logic [4:0]      w_bit_nxt;
    logic [1:0]      w_word_nxt;
    logic            w_frame_end;

    assign w_bit_nxt   = r_bit + 5'd1;
    assign w_word_nxt  = r_word + 2'd1;
    assign w_frame_end = (r_state == S_SEND) && (r_bit == 5'd31);

    // Operand buffer: writable at any time, including mid-burst.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_buf <= '0;
        end else if (wr) begin
            r_buf[{waddr, 3'b000} +: 8] <= wdata;
        end
    end

    // Transmit sequencer. tx is registered, so each transition preloads the
    // bit to be shown in the following cycle. Bit b of word i sits at
    // snap[32i + 31 - b], i.e. index {i, ~b}.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_snap  <= '0;
            add     <= 1'b0;
            tx      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_word <= '0;
                    r_bit  <= '0;
                    if (start) begin
                        // Snapshot takes the pre-write buffer on a same-cycle write.
                        r_snap  <= r_buf;
                        tx      <= r_buf[31];
                        add     <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (r_bit == 5'd31) begin
                        add   <= 1'b0;
                        tx    <= 1'b0;
                        r_bit <= '0;
                        r_gap <= '0;
                        if (r_word == c_WORD_LAST) begin
                            r_state <= S_IDLE;
                            r_word  <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_bit <= w_bit_nxt;
                        tx    <= r_snap[{r_word, ~w_bit_nxt}];
                    end
                end
                S_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_state <= S_SEND;
                        r_word  <= w_word_nxt;
                        add     <= 1'b1;
                        tx      <= r_snap[{w_word_nxt, 5'b11111}];
                    end else begin
                        r_gap <= r_gap + c_GW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ACC_TX_CHECKSUM_EN
    logic [127:0] r_sum;

    // Commits a frame's word as add drops, like the receiver. Frames cut
    // short by reset never reach bit 31 and so are never added.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_sum <= '0;
        end else if (w_frame_end) begin
            r_sum <= r_sum + {96'b0, r_snap[{r_word, 5'b00000} +: 32]};
        end
    end

    assign chk_data = r_sum[{chk_sel, 3'b000} +: 8];
`else
    logic w_unused_chk;
    assign w_unused_chk = ^{chk_sel, w_frame_end};
    assign chk_data     = 8'h00;
`endif

endmodule
`default_nettype wire
